// File: rtl/multiplier_pkg.sv
// Types for the multiplier scheduler: FSM state encoding and the grant-index
// type, sized for the largest supported requester count.
package multiplier_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int MAX_NUM_REQ     = 8;

    typedef logic [$clog2(MAX_NUM_REQ)-1:0] grant_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } sched_state_e;

endpackage : multiplier_pkg

// File: rtl/params_pkg.sv
// Arithmetic parameters shared by the Montgomery datapath: word width and the
// Dilithium modulus q = 8380417 with its bit length.
package params_pkg;

    localparam int DATA_LENGTH = 32;

    localparam logic [DATA_LENGTH-1:0] MODULUS        = 32'd8380417;
    localparam logic [DATA_LENGTH-1:0] MODULUS_LENGTH = 32'd23;

endpackage : params_pkg

// File: rtl/montgomery_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. The search starts one past the
// last served requester and wraps at NUM_REQ, so the last winner ranks lowest.
module rr_arbiter
    import multiplier_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  grant_idx_t         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output grant_idx_t         gnt_idx,
    output logic               gnt_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output of this block gets a default before the search
        // loop, so no path through it can leave a value held (no latch).
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = grant_idx_t'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/montgomery_rr_scheduler.sv
// Round-robin front end sharing one bit-serial Montgomery core among NUM_REQ
// requesters. Define MONT_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
module montgomery_rr_scheduler
    import params_pkg::*;
    import multiplier_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 4 * DATA_LENGTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_y_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    input  logic [NUM_REQ-1:0]             resp_ready_i,
    output logic [DATA_LENGTH-1:0]         resp_data_o,
    output logic                           resp_err_o,
    output logic                           mm_start_o,
    output logic [DATA_LENGTH-1:0]         mm_x_o,
    output logic [DATA_LENGTH-1:0]         mm_y_o,
    output logic [DATA_LENGTH-1:0]         mm_m_o,
    output logic [DATA_LENGTH-1:0]         mm_m_bl_o,
    input  logic [DATA_LENGTH-1:0]         mm_result_i,
    input  logic                           mm_valid_i
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("montgomery_rr_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    sched_state_e         state_q;
    grant_idx_t           ptr_q;
    grant_idx_t           gnt_idx_q;
    logic [NUM_REQ-1:0]   gnt_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    grant_idx_t           arb_idx;
    logic                 arb_any;
    logic [DATA_LENGTH-1:0] sel_x;
    logic [DATA_LENGTH-1:0] sel_y;
    logic                 resp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_x = req_x_i[i*DATA_LENGTH +: DATA_LENGTH];
                sel_y = req_y_i[i*DATA_LENGTH +: DATA_LENGTH];
            end
        end
    end

    // The accept pulse must land in the same cycle the operands are latched,
    // so it is decoded from state; rst_ni keeps it low while reset is held.
    assign req_ready_o = (state_q == IDLE && rst_ni) ? arb_gnt : '0;
    assign resp_done   = |(resp_ready_i & gnt_q);
    assign mm_m_o      = MODULUS;
    assign mm_m_bl_o   = MODULUS_LENGTH;

`ifdef MONT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
`else
    assign resp_err_o = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears the whole datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= grant_idx_t'(NUM_REQ - 1);
            gnt_idx_q    <= '0;
            gnt_q        <= '0;
            mm_start_o   <= 1'b0;
            mm_x_o       <= '0;
            mm_y_o       <= '0;
            resp_valid_o <= '0;
            resp_data_o  <= '0;
`ifdef MONT_SCHED_TIMEOUT_EN
            resp_err_o   <= 1'b0;
            wait_cnt_q   <= '0;
`endif
        end else begin
            mm_start_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q      <= arb_gnt;
                        gnt_idx_q  <= arb_idx;
                        mm_x_o     <= sel_x;
                        mm_y_o     <= sel_y;
                        mm_start_o <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
`ifdef MONT_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mm_valid_i) begin
                        resp_data_o  <= mm_result_i;
                        resp_valid_o <= gnt_q;
                        state_q      <= RESP;
`ifdef MONT_SCHED_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_o  <= '0;
                        resp_err_o   <= 1'b1;
                        resp_valid_o <= gnt_q;
                        state_q      <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    // Only the issuing requester's ready can retire the result.
                    if (resp_done) begin
                        resp_valid_o <= '0;
                        ptr_q        <= gnt_idx_q;
                        state_q      <= IDLE;
`ifdef MONT_SCHED_TIMEOUT_EN
                        resp_err_o   <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : montgomery_rr_scheduler

// File: tb/tb_montgomery_rr_scheduler.sv
// Self-checking bench for montgomery_rr_scheduler with a behavioural bit-serial
// Montgomery core; results are checked against (x*y) mod q via a scoreboard.
module tb_montgomery_rr_scheduler;
    import params_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int DL       = DATA_LENGTH;
    localparam int TIMEOUT  = 4 * DATA_LENGTH;
    localparam int CORE_LAT = 24;
    localparam int MAX_OPS  = 16;

    typedef struct {
        int          req;
        logic [31:0] data;
        logic        err;
    } sb_entry_t;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*DL-1:0]   req_x_i;
    logic [NUM_REQ*DL-1:0]   req_y_i;
    logic [NUM_REQ-1:0]      resp_valid_o;
    logic [NUM_REQ-1:0]      resp_ready_i;
    logic [DL-1:0]           resp_data_o;
    logic                    resp_err_o;
    logic                    mm_start_o;
    logic [DL-1:0]           mm_x_o, mm_y_o, mm_m_o, mm_m_bl_o;
    logic [DL-1:0]           mm_result_i;
    logic                    mm_valid_i;

    logic                    core_busy, core_valid, core_mute;
    int                      core_cnt;
    logic [DL-1:0]           core_result;
    logic                    inject_valid;
    logic [DL-1:0]           inject_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DL-1:0] op_x  [NUM_REQ][MAX_OPS];
    logic [DL-1:0] op_yn [NUM_REQ][MAX_OPS];
    int            n_ops [NUM_REQ];
    int            op_pos[NUM_REQ];
    int            acc_total[NUM_REQ];
    int            acc_done [NUM_REQ];
    int            ready_seen[NUM_REQ];
    sb_entry_t     sb[$];
    sb_entry_t     mon_e;
    int            grant_log[$];
    logic          exp_err_next;
    int            start_cnt = 0;
    int            last_acc_cyc = 0, last_start_cyc = 0, last_mmv_cyc = 0;
    logic [NUM_REQ-1:0] prev_rv = '0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    assign mm_valid_i  = core_valid | inject_valid;
    assign mm_result_i = inject_valid ? inject_data : core_result;

    montgomery_rr_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_x_i      (req_x_i),
        .req_y_i      (req_y_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .mm_start_o   (mm_start_o),
        .mm_x_o       (mm_x_o),
        .mm_y_o       (mm_y_o),
        .mm_m_o       (mm_m_o),
        .mm_m_bl_o    (mm_m_bl_o),
        .mm_result_i  (mm_result_i),
        .mm_valid_i   (mm_valid_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] to_mont(input logic [31:0] yn);
        return 32'((64'(yn) << 23) % 64'(MODULUS));
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] yn);
        return 32'((64'(x) * 64'(yn)) % 64'(MODULUS));
    endfunction

    // Radix-2 Montgomery product x*y*2^-n mod m, the way the serial core does it.
    function automatic logic [31:0] mont_mul(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] m, input logic [31:0] n);
        logic [63:0] a;
        a = '0;
        for (int i = 0; i < int'(n); i++) begin
            if (x[i]) a = a + 64'(y);
            if (a[0]) a = a + 64'(m);
            a = a >> 1;
        end
        if (a >= 64'(m)) a = a - 64'(m);
        return a[31:0];
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_busy   <= 1'b0;
            core_cnt    <= 0;
            core_valid  <= 1'b0;
            core_result <= '0;
        end else begin
            core_valid <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 0) begin
                    core_busy   <= 1'b0;
                    core_valid  <= 1'b1;
                    core_result <= mont_mul(mm_x_o, mm_y_o, mm_m_o, mm_m_bl_o);
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end else if (mm_start_o && !core_mute) begin
                core_busy <= 1'b1;
                core_cnt  <= CORE_LAT - 1;
            end
        end
    end

    // Monitor: records accepts into the scoreboard and retires responses.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_o[i]) ready_seen[i]++;
                if (req_valid_i[i] && req_ready_o[i]) begin
                    mon_e.req  = i;
                    mon_e.err  = exp_err_next;
                    mon_e.data = exp_err_next ? '0 : ref_mul(op_x[i][op_pos[i]], op_yn[i][op_pos[i]]);
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                    acc_total[i]++;
                    last_acc_cyc = cyc;
                end
            end
            if (mm_start_o) begin
                check("start_latency", 64'(cyc - last_acc_cyc), 64'd1);
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (core_valid) last_mmv_cyc = cyc;
            if (resp_valid_o != '0 && prev_rv == '0) begin
                if (sb.size() > 0 && sb[0].err)
                    check("timeout_latency", 64'(cyc - last_start_cyc), 64'(TIMEOUT + 1));
                else
                    check("resp_latency", 64'(cyc - last_mmv_cyc), 64'd1);
            end
            if ((resp_valid_o & resp_ready_i) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid_o), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_owner", 64'(resp_valid_o), 64'(1 << mon_e.req));
                    check("resp_data", 64'(resp_data_o), 64'(mon_e.data));
                    check("resp_err", 64'(resp_err_o), 64'(mon_e.err));
                end
            end
        end
        prev_rv = resp_valid_o;
    end

    task automatic present(input int i);
        if (op_pos[i] < n_ops[i]) begin
            req_valid_i[i]         = 1'b1;
            req_x_i[i*DL +: DL]    = op_x[i][op_pos[i]];
            req_y_i[i*DL +: DL]    = to_mont(op_yn[i][op_pos[i]]);
        end else begin
            req_valid_i[i] = 1'b0;
        end
    endtask

    task automatic add_op(input int i, input logic [31:0] x, input logic [31:0] yn);
        op_x[i][n_ops[i]]  = x;
        op_yn[i][n_ops[i]] = yn;
        n_ops[i]++;
        if (!req_valid_i[i]) present(i);
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            n_ops[i]    = 0;
            op_pos[i]   = 0;
            acc_done[i] = acc_total[i];
        end
        req_valid_i = '0;
        sb.delete();
    endtask

    // One clock; afterwards each requester whose operand was accepted moves on.
    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_total[i] != acc_done[i]) begin
                acc_done[i] = acc_total[i];
                op_pos[i]++;
                present(i);
            end
        end
    endtask

    function automatic bit is_idle();
        bit ok;
        ok = (sb.size() == 0) && (resp_valid_o == '0);
        for (int i = 0; i < NUM_REQ; i++)
            if (op_pos[i] < n_ops[i] || acc_total[i] != acc_done[i]) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(is_idle()), 64'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        check({pfx, "_req_ready"}, 64'(req_ready_o), 64'd0);
        check({pfx, "_mm_start"}, 64'(mm_start_o), 64'd0);
        check({pfx, "_resp_err"}, 64'(resp_err_o), 64'd0);
        check({pfx, "_resp_data"}, 64'(resp_data_o), 64'd0);
        check({pfx, "_mm_x"}, 64'(mm_x_o), 64'd0);
        check({pfx, "_mm_y"}, 64'(mm_y_o), 64'd0);
    endtask

    task automatic reset_dut();
        #1;
        rst_ni = 1'b0;
        clear_ops();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, chg, rdy, n, r1, r3;
        logic [DL-1:0] d0;
        rst_ni       = 1'b0;
        req_valid_i  = '0;
        req_x_i      = '0;
        req_y_i      = '0;
        resp_ready_i = '1;
        inject_valid = 1'b0;
        inject_data  = '0;
        core_mute    = 1'b0;
        exp_err_next = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_total[i]  = 0;
            ready_seen[i] = 0;
        end
        clear_ops();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        check("mm_m", 64'(mm_m_o), 64'(MODULUS));
        check("mm_m_bl", 64'(mm_m_bl_o), 64'(MODULUS_LENGTH));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // 1: single request from requester 0
        s0 = start_cnt;
        add_op(0, 32'h1, 32'h2);
        wait_idle("t1_idle", 200);
        check("t1_start_pulses", 64'(start_cnt - s0), 64'd1);
        check("t1_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

        // 2: all four at once, fresh pointer after reset
        reset_dut();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) add_op(i, 32'(3 + i), 32'h7);
        wait_idle("t2_idle", 600);
        check("t2_grant_count", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check($sformatf("t2_grant%0d", k), 64'(grant_log[k]), 64'(k));

        // 3: fairness between two continuously valid requesters
        grant_log.delete();
        r1 = ready_seen[1];
        r3 = ready_seen[3];
        for (int k = 0; k < 3; k++) begin
            add_op(0, 32'h100 + 32'(k), 32'h9 + 32'(k));
            add_op(2, 32'h7ABCDE - 32'(k), 32'h1234 + 32'(k));
        end
        wait_idle("t3_idle", 900);
        check("t3_grant_count", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check($sformatf("t3_grant%0d", k), 64'(grant_log[k]), 64'((k % 2) * 2));
        check("t3_req1_ready", 64'(ready_seen[1] - r1), 64'd0);
        check("t3_req3_ready", 64'(ready_seen[3] - r3), 64'd0);

        // 4: response backpressure on requester 1
        grant_log.delete();
        resp_ready_i[1] = 1'b0;
        add_op(1, 32'h123, 32'h456);
        n = 0;
        while (resp_valid_o[1] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t4_resp_up", 64'(resp_valid_o), 64'b0010);
        add_op(0, 32'h55, 32'h66);
        d0  = resp_data_o;
        s0  = start_cnt;
        chg = 0;
        rdy = 0;
        repeat (20) begin
            tick();
            if (resp_valid_o !== 4'b0010 || resp_data_o !== d0) chg++;
            if (req_ready_o !== '0) rdy++;
        end
        check("t4_data", 64'(d0), 64'(ref_mul(32'h123, 32'h456)));
        check("t4_stable", 64'(chg), 64'd0);
        check("t4_no_ready", 64'(rdy), 64'd0);
        check("t4_no_start", 64'(start_cnt - s0), 64'd0);
        resp_ready_i[1] = 1'b1;
        wait_idle("t4_idle", 300);
        check("t4_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("t4_grant0", 64'(grant_log[0]), 64'd1);
            check("t4_grant1", 64'(grant_log[1]), 64'd0);
        end

        // 5: reset while the core is busy, then a stale strobe during START
        s0 = start_cnt;
        add_op(2, 32'h1234, 32'h10);
        n = 0;
        while (start_cnt == s0 && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        clear_ops();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        add_op(3, 32'h7FE000, 32'h5);
        n = 0;
        while (mm_start_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t5_in_start", 64'(mm_start_o), 64'd1);
        inject_valid = 1'b1;
        inject_data  = 32'h0BAD;
        tick();
        inject_valid = 1'b0;
        wait_idle("t5_idle", 200);
        check("t5_ref", 64'(ref_mul(32'h7FE000, 32'h5)), 64'(MODULUS - 5));

`ifdef MONT_SCHED_TIMEOUT_EN
        // 6: core never answers, scheduler must abort with an error response
        core_mute    = 1'b1;
        exp_err_next = 1'b1;
        add_op(1, 32'h11, 32'h22);
        wait_idle("t6_idle", TIMEOUT + 100);
        core_mute    = 1'b0;
        exp_err_next = 1'b0;
        add_op(1, 32'h33, 32'h44);
        wait_idle("t6_recover", 200);
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_montgomery_rr_scheduler
